// File: rtl/wb_periph_hub.sv
// Wishbone hub: decodes the user region onto NUM_SLOTS peripheral slots with a
// bus timeout, plus a small CSR block that aggregates interrupt sources onto user_irq.
module wb_periph_hub #(
  parameter int          NUM_SLOTS   = 4,
  parameter int          SLOT_AW     = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          TIMEOUT     = 15,
  parameter int          NUM_IRQ_SRC = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_SLOTS-1:0]    s_stb_o,
  output logic                    s_we_o,
  output logic [3:0]              s_sel_o,
  output logic [SLOT_AW-1:0]      s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic [NUM_SLOTS-1:0]    s_ack_i,
  input  logic [NUM_SLOTS*32-1:0] s_dat_i,
  input  logic [NUM_IRQ_SRC-1:0]  irq_src_i,
  output logic [2:0]              user_irq
);

  localparam int          N        = NUM_IRQ_SRC;
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;
  state_e state_q, state_d;

  logic [NUM_SLOTS-1:0] stb_q, stb_d;
  logic                 we_q, we_d, ack_q;
  logic [3:0]           sel_q, sel_d, idx_q, idx_d, eidx_q, eidx_d;
  logic [SLOT_AW-1:0]   adr_q, adr_d;
  logic [31:0]          wdat_q, wdat_d, rdat_q, rdat_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 derr_q, derr_d, tout_q, tout_d;
  logic [N-1:0]         src_q, pend_q, pend_d, mask_q, mask_d;
  logic [2*N-1:0]       route_q, route_d;
  logic [2:0]           irq_q, irq_d;

  logic [3:0]  a_idx;
  logic [2:0]  off;
  logic        hit, slot_hit, csr_hit, ack_hit, csr_we, set_derr, set_tout;
  logic [31:0] slot_rd, csr_rd;
  logic [2*N-1:0] wm_r, wd_r;

  assign a_idx    = wbs_adr_i[SLOT_AW+3:SLOT_AW];
  assign off      = wbs_adr_i[4:2];
  assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:SLOT_AW+4] == BASE_ADDR[31:SLOT_AW+4]);
  assign slot_hit = hit & ({1'b0, a_idx} < 5'(NUM_SLOTS));
  assign csr_hit  = hit & (a_idx == 4'hF);
  // stb_q is the one-hot of the selected slot, so it also masks acks from other slots
  assign ack_hit  = |(s_ack_i & stb_q);

  for (genvar b = 0; b < 2*N; b++) begin : g_wm
    assign wm_r[b] = wbs_sel_i[b/8];
  end
  assign wd_r = wbs_dat_i[2*N-1:0] & wm_r;

  always_comb begin
    slot_rd = '0;
    for (int n = 0; n < NUM_SLOTS; n++)
      if (stb_q[n]) slot_rd = s_dat_i[n*32 +: 32];
  end

  always_comb begin
    case (off)
      3'd0:    csr_rd = {8'h02, 8'(NUM_SLOTS), 8'(NUM_IRQ_SRC), 8'(TIMEOUT)};
      3'd1:    csr_rd = {24'h0, eidx_q, 2'b00, tout_q, derr_q};
      3'd2:    csr_rd = 32'(pend_q);
      3'd3:    csr_rd = 32'(mask_q);
      3'd4:    csr_rd = 32'(route_q);
      default: csr_rd = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    stb_d    = stb_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rdat_d   = rdat_q;
    eidx_d   = eidx_q;
    csr_we   = 1'b0;
    set_derr = 1'b0;
    set_tout = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_hit) begin
          for (int n = 0; n < NUM_SLOTS; n++) stb_d[n] = (a_idx == 4'(n));
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          adr_d   = wbs_adr_i[SLOT_AW-1:0];
          wdat_d  = wbs_dat_i;
          idx_d   = a_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end else if (csr_hit) begin
          csr_we  = wbs_we_i;
          if (!wbs_we_i) rdat_d = csr_rd;
          state_d = ACK;
        end else if (hit) begin
          rdat_d   = SENTINEL;
          set_derr = 1'b1;
          eidx_d   = a_idx;
          state_d  = ACK;
        end
      end
      BUSY: begin
        if (!wbs_cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (ack_hit) begin
          if (!we_q) rdat_d = slot_rd;
          stb_d   = '0;
          state_d = ACK;
        end else if (cnt_q == 8'(TIMEOUT-1)) begin
          stb_d    = '0;
          rdat_d   = SENTINEL;
          set_tout = 1'b1;
          eidx_d   = idx_q;
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hardware set events take priority over software write-1-to-clear
  always_comb begin
    derr_d  = set_derr | (derr_q & ~(csr_we && off == 3'd1 && wd_r[0]));
    tout_d  = set_tout | (tout_q & ~(csr_we && off == 3'd1 && wd_r[1]));
    pend_d  = (irq_src_i & ~src_q) | (pend_q & ~((csr_we && off == 3'd2) ? wd_r[N-1:0] : '0));
    mask_d  = (csr_we && off == 3'd3) ? ((mask_q & ~wm_r[N-1:0]) | wd_r[N-1:0]) : mask_q;
    route_d = (csr_we && off == 3'd4) ? ((route_q & ~wm_r) | wd_r) : route_q;
    irq_d   = '0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++)
        if (pend_q[i] && mask_q[i] && route_q[2*i +: 2] == 2'(k)) irq_d[k] = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      stb_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      derr_q  <= 1'b0;
      tout_q  <= 1'b0;
      eidx_q  <= '0;
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      route_q <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == ACK);
      rdat_q  <= rdat_d;
      derr_q  <= derr_d;
      tout_q  <= tout_d;
      eidx_q  <= eidx_d;
      src_q   <= irq_src_i;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      route_q <= route_d;
      irq_q   <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign s_stb_o   = stb_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = wdat_q;
  assign user_irq  = irq_q;

endmodule

// File: tb/tb_wb_periph_hub.sv
// Randomized bench for wb_periph_hub against a transaction-level model of the
// hub's CSRs, error reporting and cycle timing.
module tb_wb_periph_hub;
  localparam int NS = 4, AW = 12, TO = 15, NI = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat;
  logic [NS-1:0]   s_stb;
  logic            s_we;
  logic [3:0]      s_sel;
  logic [AW-1:0]   s_adr;
  logic [31:0]     s_wdat;
  logic [NS-1:0]   s_ack;
  logic [NS*32-1:0] s_rdat;
  logic [NI-1:0]   irq_src;
  logic [2:0]      uirq;

  always #5 clk = ~clk;

  wb_periph_hub #(.NUM_SLOTS(NS), .SLOT_AW(AW), .BASE_ADDR(32'h3000_0000),
                  .TIMEOUT(TO), .NUM_IRQ_SRC(NI)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_dat_i(s_rdat), .irq_src_i(irq_src), .user_irq(uirq));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference state
  logic [7:0]  m_pend, m_mask, m_src;
  logic [15:0] m_route;
  logic        m_derr, m_tout;
  logic [3:0]  m_eidx;
  logic [31:0] m_dat;

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_src = 0; m_route = 0;
    m_derr = 0; m_tout = 0; m_eidx = 0; m_dat = 0;
  endtask

  function automatic logic [31:0] m_csr(input logic [2:0] o);
    case (o)
      3'd0:    return 32'h0204_080F;
      3'd1:    return {24'h0, m_eidx, 2'b00, m_tout, m_derr};
      3'd2:    return {24'h0, m_pend};
      3'd3:    return {24'h0, m_mask};
      3'd4:    return {16'h0, m_route};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_csr_wr(input logic [2:0] o, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] wm, wd;
    wm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    wd = d & wm;
    case (o)
      3'd1: begin if (wd[0]) m_derr = 0; if (wd[1]) m_tout = 0; end
      3'd2: m_pend = m_pend & ~wd[7:0];
      3'd3: m_mask = (m_mask & ~wm[7:0]) | wd[7:0];
      3'd4: m_route = (m_route & ~wm[15:0]) | wd[15:0];
      default: ;
    endcase
  endtask

  function automatic logic [2:0] m_irq();
    logic [2:0] r = 0;
    for (int i = 0; i < NI; i++)
      if (m_pend[i] && m_mask[i] && m_route[2*i +: 2] != 2'd3) r[m_route[2*i +: 2]] = 1'b1;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_src(input logic [7:0] v);
    irq_src = v;
    m_pend  = m_pend | (v & ~m_src);
    m_src   = v;
  endtask

  // Drives one master access; slot `slot` acks in cycle `lat` (never if lat==0), others get noise.
  task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                     input int slot, input int lat, input logic [31:0] sd,
                     output int ackc, output logic [31:0] rd, output int stbc, output int stbbad,
                     output logic [AW-1:0] f_adr, output logic f_we, output logic [3:0] f_sel,
                     output logic [31:0] f_dat);
    logic [NS-1:0] tgt;
    tgt = (slot >= 0 && slot < NS) ? NS'(1 << slot) : '0;
    adr = a; we = w; sel = s; wdat = d; cyc = 1; stb = 1;
    for (int n = 0; n < NS; n++) s_rdat[n*32 +: 32] = (n == slot) ? sd : $urandom;
    ackc = -1; rd = 0; stbc = 0; stbbad = 0; f_adr = 0; f_we = 0; f_sel = 0; f_dat = 0;
    for (int c = 0; c < TO + 6; c++) begin
      s_ack = (NS'($urandom) & ~tgt) | ((c == lat) ? tgt : '0);
      @(negedge clk);
      if (s_stb != 0) begin
        if (stbc == 0) begin f_adr = s_adr; f_we = s_we; f_sel = s_sel; f_dat = s_wdat; end
        stbc++;
        if (s_stb !== tgt) stbbad++;
      end
      if (ack) begin ackc = c; rd = rdat; end
      @(posedge clk); #1;
      if (ackc >= 0) break;
    end
    cyc = 0; stb = 0; s_ack = 0;
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input int lat, input logic [31:0] sd);
    int ackc, stbc, stbbad, slot, exp_ack, exp_stb;
    logic [31:0] rd, f_dat;
    logic [AW-1:0] f_adr;
    logic f_we;
    logic [3:0] f_sel, idx;
    logic hitr;
    hitr = (a[31:16] == 16'h3000);
    idx  = a[15:12];
    slot = (hitr && idx < NS) ? int'(idx) : -1;
    bus(a, w, s, d, slot, lat, sd, ackc, rd, stbc, stbbad, f_adr, f_we, f_sel, f_dat);
    exp_stb = 0;
    if (!hitr) exp_ack = -1;
    else if (slot >= 0) begin
      if (lat >= 1 && lat <= TO) begin
        exp_ack = lat + 1; exp_stb = lat;
        if (!w) m_dat = sd;
      end else begin
        exp_ack = TO + 1; exp_stb = TO;
        m_dat = 32'hDEAD_BEEF; m_tout = 1; m_eidx = idx;
      end
      chk("slot_stb_onehot_bad", stbbad, 0);
      chk("slot_adr", 32'(f_adr), 32'(a[AW-1:0]));
      chk("slot_we_sel", {f_we, f_sel}, {w, s});
      chk("slot_wdat", f_dat, d);
    end else if (idx == 4'hF) begin
      exp_ack = 1;
      if (w) m_csr_wr(a[4:2], s, d);
      else   m_dat = m_csr(a[4:2]);
    end else begin
      exp_ack = 1;
      m_dat = 32'hDEAD_BEEF; m_derr = 1; m_eidx = idx;
    end
    chk("ack_cycle", 32'(ackc), 32'(exp_ack));
    chk("stb_cycles", 32'(stbc), 32'(exp_stb));
    if (ackc >= 0) chk("rdata", rd, m_dat);
    @(negedge clk);
    chk("ack_one_cycle", {31'h0, ack}, 32'h0);
    tick(1);
  endtask

  task automatic csr_rd(input logic [2:0] o);
    do_xfer({16'h3000, 4'hF, 7'h0, o, 2'b00}, 1'b0, 4'hF, 32'h0, 0, 32'h0);
  endtask

  task automatic csr_wr(input logic [2:0] o, input logic [3:0] s, input logic [31:0] d);
    do_xfer({16'h3000, 4'hF, 7'h0, o, 2'b00}, 1'b1, s, d, 0, 32'h0);
  endtask

  initial begin
    int acks;
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    s_ack = 0; s_rdat = 0; irq_src = 0; rst_n = 0;
    m_reset();
    tick(3);
    rst_n = 1;
    @(negedge clk);
    chk("rst_outs", {ack, s_stb, s_we, uirq}, 0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_sadr", 32'(s_adr), 32'h0);
    tick(1);
    csr_rd(3'd0);
    chk("id_const", m_dat, 32'h0204_080F);
    csr_rd(3'd1);

    // slot 2 read acked in cycle 3
    do_xfer(32'h3000_2010, 1'b0, 4'hF, 32'h0, 3, 32'hCAFE_0001);
    chk("plan_slot2_data", rdat, 32'hCAFE_0001);
    // slot 1 write never acked -> timeout
    do_xfer(32'h3000_1004, 1'b1, 4'hF, 32'h1234_5678, 0, 32'h0);
    csr_rd(3'd1);
    chk("plan_status_tout", m_dat, 32'h12);
    csr_wr(3'd1, 4'hF, 32'h2);
    csr_rd(3'd1);
    // decode error and region miss
    do_xfer(32'h3000_6000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    csr_rd(3'd1);
    chk("plan_status_derr", m_dat, 32'h61);
    do_xfer(32'h4000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    csr_wr(3'd1, 4'hF, 32'h3);

    // interrupt path timing
    csr_wr(3'd3, 4'hF, 32'h1);
    csr_wr(3'd4, 4'hF, 32'h2);
    set_src(8'h01);
    @(negedge clk); chk("irq_c0", 32'(uirq), 32'h0);
    tick(1); @(negedge clk); chk("irq_c1", 32'(uirq), 32'h0);
    tick(1); @(negedge clk); chk("irq_c2", 32'(uirq), 32'h4);
    chk("irq_model", 32'(uirq), 32'(m_irq()));
    tick(1);
    set_src(8'h00);
    tick(2);
    // W1C in the same cycle as a new rising edge: set wins
    irq_src = 8'h01;
    csr_wr(3'd2, 4'hF, 32'h1);
    m_pend = m_pend | (8'h01 & ~m_src);
    m_src  = 8'h01;
    csr_rd(3'd2);
    chk("pend_set_wins", m_dat, 32'h1);

    // master abort during BUSY
    adr = 32'h3000_0000; we = 0; sel = 4'hF; cyc = 1; stb = 1; s_ack = 0;
    tick(2); @(negedge clk); chk("abort_stb_busy", 32'(s_stb), 32'h1);
    tick(1); cyc = 0; stb = 0;
    tick(1); @(negedge clk); chk("abort_stb_drop", 32'(s_stb), 32'h0);
    acks = 0;
    for (int c = 0; c < 20; c++) begin tick(1); @(negedge clk); if (ack) acks++; end
    chk("abort_no_ack", 32'(acks), 32'h0);

    // reset during BUSY
    set_src(8'h00);
    tick(2);
    adr = 32'h3000_1000; cyc = 1; stb = 1;
    tick(3); #2;
    rst_n = 0;
    #1;
    chk("rst_busy_outs", {ack, s_stb, uirq}, 0);
    chk("rst_busy_dat", rdat, 32'h0);
    cyc = 0; stb = 0;
    tick(1); rst_n = 1; m_reset();
    acks = 0;
    for (int c = 0; c < 20; c++) begin tick(1); @(negedge clk); if (ack) acks++; end
    chk("rst_no_late_ack", 32'(acks), 32'h0);
    tick(1);
    csr_rd(3'd3);

    // byte-lane write
    csr_wr(3'd3, 4'b0001, 32'hFFFF_FFFF);
    csr_rd(3'd3);
    chk("mask_sel_byte0", m_dat, 32'h0000_00FF);

    // randomized mix
    for (int it = 0; it < 120; it++) begin
      int op;
      logic [3:0] ix;
      op = $urandom_range(0, 6);
      case (op)
        0, 1: begin
          ix = 4'($urandom_range(0, NS-1));
          do_xfer({16'h3000, ix, 12'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
                  $urandom_range(0, 18), $urandom);
        end
        2: csr_wr(3'($urandom_range(0, 5)), 4'($urandom), $urandom);
        3: csr_rd(3'($urandom));
        4: begin
          ix = 4'($urandom_range(NS, 14));
          do_xfer({16'h3000, ix, 12'($urandom)}, 1'($urandom), 4'hF, $urandom, 1, $urandom);
        end
        5: begin
          logic [15:0] up;
          up = 16'($urandom);
          if (up == 16'h3000) up = 16'h3001;
          do_xfer({up, 16'($urandom)}, 1'($urandom), 4'hF, $urandom, 1, $urandom);
        end
        default: begin
          set_src(8'($urandom));
          tick(2);
        end
      endcase
      @(negedge clk);
      chk("user_irq", 32'(uirq), 32'(m_irq()));
      tick(1);
    end
    csr_rd(3'd1);
    csr_rd(3'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_periph_hub.md
# wb_periph_hub

Parametrised Wishbone peripheral hub between the Caravel management-SoC slave port and up to 8 user peripheral slots inside the user project wrapper. It decodes the user address region, forwards each access to one slot with a registered request, and enforces a bus timeout. It returns a sentinel on decode or timeout errors. It also aggregates peripheral interrupt sources onto the three `user_irq` lines through pending, mask and route registers.

## Interface
- `NUM_SLOTS`, 4: number of peripheral slots, 1..8.
- `SLOT_AW`, 12: byte-address bits per slot.
- `BASE_ADDR`, 32'h3000_0000: region base. Bits below `SLOT_AW+4` are ignored.
- `TIMEOUT`, 15: maximum slot wait in cycles, 1..255.
- `NUM_IRQ_SRC`, 8: interrupt sources, 1..16.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic master control.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_dat_o` out 32: read data, registered.
- `s_stb_o` out `NUM_SLOTS`: one-hot slot strobe.
- `s_we_o` out 1, `s_sel_o` out 4, `s_adr_o` out `SLOT_AW`, `s_dat_o` out 32: shared slot request fields, registered.
- `s_ack_i` in `NUM_SLOTS`: slot acknowledges.
- `s_dat_i` in `NUM_SLOTS*32`: slot read data. Slot n occupies bits [32n+31:32n].
- `irq_src_i` in `NUM_IRQ_SRC`: level interrupt sources, synchronous to `wb_clk_i`.
- `user_irq` out 3: interrupt lines, registered.

## Operation
- Region hit: `wbs_cyc_i & wbs_stb_i` with `wbs_adr_i[31:SLOT_AW+4]` equal to `BASE_ADDR[31:SLOT_AW+4]`. A miss is ignored, with no ack and no state change.
- Slot index is `wbs_adr_i[SLOT_AW+3:SLOT_AW]`:
  - index < `NUM_SLOTS`: slot access.
  - index 15: hub CSR.
  - any other index: decode error.
- The FSM has three states: IDLE, BUSY, ACK.
  - IDLE, slot hit: latch we, sel, adr[SLOT_AW-1:0], dat and index; assert `s_stb_o[index]`; clear the timeout counter; go to BUSY.
  - IDLE, CSR hit: perform the access; register the read data; go to ACK.
  - IDLE, decode error: `wbs_dat_o`=32'hDEAD_BEEF; set STATUS.derr; record the index; go to ACK.
  - BUSY, `s_ack_i[index]` high: register the selected `s_dat_i` slice; drop `s_stb_o`; go to ACK.
  - BUSY, counter reaches `TIMEOUT` with no ack: drop `s_stb_o`; `wbs_dat_o`=32'hDEAD_BEEF; set STATUS.tout; record the index; go to ACK.
  - BUSY, `wbs_cyc_i` low: abort. Drop `s_stb_o` and go to IDLE with no ack.
  - ACK: `wbs_ack_o`=1 for exactly one cycle, then IDLE. A strobe still high in the following IDLE cycle is a new transaction.
- Acks from non-selected slots are ignored. On writes, `wbs_dat_o` keeps its previous value.
- CSRs use offset `wbs_adr_i[4:2]`. Writes honour `wbs_sel_i`.
  - 0x00 ID, read-only: {8'h02, 8'(NUM_SLOTS), 8'(NUM_IRQ_SRC), 8'(TIMEOUT)}.
  - 0x04 STATUS: [0] derr, [1] tout, [7:4] last error index. Bits [1:0] are write-1-to-clear.
  - 0x08 IRQ_PEND: write-1-to-clear. Bit i sets on a rising edge of `irq_src_i[i]`, i.e. the previous registered sample was 0 and the current is 1.
  - 0x0C IRQ_MASK: read/write, reset 0.
  - 0x10 IRQ_ROUTE: 2 bits per source select line 0..2. Value 3 disables the source. Reset 0.
  - Other offsets read 0; writes to them are ignored.
- Next-cycle value of `user_irq[k]` = OR over i of (PEND[i] & MASK[i] & ROUTE[i]==k).
- A pending set and a write-1-to-clear on the same bit in the same cycle: the set wins. The same rule applies to STATUS error bits.
- Bits at or above `NUM_IRQ_SRC` read 0 and are not writable.

## Timing
- Reset: all outputs are 0, FSM in IDLE, all CSRs are 0. Asserting `wb_rst_ni` mid-transaction drops `s_stb_o` and `wbs_ack_o` immediately; no ack is issued later.
- Slot access:
  - master strobe in cycle 0;
  - `s_stb_o` high from cycle 1;
  - slot ack seen in cycle k (k≥1);
  - `wbs_ack_o` in cycle k+1.
  - Minimum slot latency is 2 cycles.
- CSR access and decode error: `wbs_ack_o` in cycle 1.
- Timeout: with no slot ack, `s_stb_o` is high for exactly `TIMEOUT` cycles and `wbs_ack_o` occurs in cycle `TIMEOUT`+1.
- Interrupt path: source rising edge in cycle 0 → PEND set in cycle 1 → `user_irq` in cycle 2.

## Test plan
- Read slot 2 at 0x3000_2010; slot acks in cycle 3 with 32'hCAFE_0001 → `s_stb_o`=4'b0100, `s_adr_o`=12'h010, `wbs_ack_o` in cycle 4 with data 32'hCAFE_0001.
- Write to slot 1 that is never acked, `TIMEOUT`=15 → ack in cycle 16, data 32'hDEAD_BEEF, STATUS reads 32'h12. Writing 32'h2 to STATUS clears tout.
- Access to index 6 with `NUM_SLOTS`=4 → ack in cycle 1, data 32'hDEAD_BEEF, STATUS=32'h61, no `s_stb_o` activity. Access to 0x4000_0000 → no ack.
- MASK=32'h1, ROUTE=32'h2, pulse `irq_src_i[0]` → `user_irq`=3'b100 two cycles later. Write-1-to-clear PEND in the same cycle as a new rising edge → PEND stays 1.
- Drop `wbs_cyc_i` during BUSY → `s_stb_o` falls the next cycle, no ack. Assert reset during BUSY → all outputs 0 immediately.
- CSR write to MASK with `wbs_sel_i`=4'b0001 and data 32'hFFFF_FFFF → reads back 32'h0000_00FF.
